// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the CLA accumulator slice:
//   - state_t     : accumulator FSM states (IDLE, ACCUM, DONE)
//   - DEF_WIDTH   : default operand / accumulator width
//   - DEF_GROUP   : default carry-look-ahead group size
//   - DEF_CNT_W   : default frame-length / beat counter width
//   - width_ok()  : elaboration-time check that WIDTH is a multiple of GROUP
// -----------------------------------------------------------------------------
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_GROUP = 4;
    localparam int DEF_CNT_W = 8;

    // The adder splits the word into equal groups, so a ragged last group is
    // not supported.
    function automatic bit width_ok(input int width, input int group);
        return (group > 0) && (width > 0) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_accumulator_cla.sv
// -----------------------------------------------------------------------------
// Carry_Look_Ahead_Adder
// Purely combinational WIDTH-bit carry-look-ahead adder built from GROUP-bit
// blocks. Inside a block every carry is the expanded generate/propagate sum of
// products; between blocks the group generate/propagate pair forms the carry
// chain.
// Ports:
//   a    in  WIDTH    first operand
//   b    in  WIDTH    second operand
//   sum  out WIDTH+1  a + b; bit WIDTH is the carry-out
// -----------------------------------------------------------------------------
module Carry_Look_Ahead_Adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    localparam int NGRP = WIDTH / GROUP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic cg;   // carry into the current group
        logic c;    // carry into the current bit
        logic pr;   // running propagate product inside the group
        logic gg;   // group generate
        logic gp;   // group propagate
        // NOTE: every output and local gets a value before any branch or loop
        // reads it, so this block can never infer a latch.
        sum = '0;
        cg  = 1'b0;
        c   = 1'b0;
        pr  = 1'b1;
        gg  = 1'b0;
        gp  = 1'b1;
        for (int k = 0; k < NGRP; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                // c_i = g[i-1] | p[i-1]g[i-2] | ... | p[i-1]..p[0]cg
                pr = 1'b1;
                c  = 1'b0;
                for (int j = i - 1; j >= 0; j--) begin
                    c  = c | (g[k*GROUP+j] & pr);
                    pr = pr & p[k*GROUP+j];
                end
                c = c | (cg & pr);
                sum[k*GROUP+i] = p[k*GROUP+i] ^ c;
                gg = g[k*GROUP+i] | (p[k*GROUP+i] & gg);
                gp = gp & p[k*GROUP+i];
            end
            cg = gg | (gp & cg);
        end
        sum[WIDTH] = cg;
    end

endmodule

// File: rtl/cla_accumulator.sv
// -----------------------------------------------------------------------------
// cla_accumulator
// Sums a frame of `len` operands, one per cycle, by feeding the running total
// back into a carry-look-ahead adder. The result and a sticky carry flag are
// offered on a valid/ready output.
//
// Optional feature (macro CLA_ACC_SAT_EN):
//   defined   - a carry-out saturates the total to all ones for the rest of
//               the frame; out_carry still reports the sticky carry.
//   undefined - modular wrap-around.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   start      in   1      frame request, sampled only in IDLE
//   len        in   CNT_W  operands in the frame, sampled with start
//   in_valid   in   1      operand valid
//   in_ready   out  1      operand accepted when in_valid && in_ready
//   in_data    in   WIDTH  operand
//   out_valid  out  1      result valid
//   out_ready  in   1      result consumed when out_valid && out_ready
//   out_sum    out  WIDTH  accumulated total
//   out_carry  out  1      sticky carry-out over the frame
//   out_count  out  CNT_W  beats accepted in the frame
//   busy       out  1      high in ACCUM or DONE
// -----------------------------------------------------------------------------
module cla_accumulator
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    generate
        if (!width_ok(WIDTH, GROUP)) begin : g_bad_width
            $error("cla_accumulator: WIDTH must be a positive multiple of GROUP");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] acc_next;
    logic             in_fire;
    logic             last_beat;

    Carry_Look_Ahead_Adder #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) u_adder (
        .a   (acc),
        .b   (in_data),
        .sum (sum_full)
    );

`ifdef CLA_ACC_SAT_EN
    // Once saturated the total is all ones, so any further non-zero operand
    // carries again and keeps it there; a zero operand leaves it unchanged.
    assign acc_next = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];
`else
    assign acc_next = sum_full[WIDTH-1:0];
`endif

    assign in_fire   = in_valid && in_ready;
    assign last_beat = (cnt == len_q - CNT_W'(1));

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (in_fire && last_beat) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    // NOTE: the datapath is a handful of flops, not a memory, so all of it is
    // cleared by the asynchronous reset to make the outputs read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        len_q <= len;
                    end
                end
                ACCUM: begin
                    if (in_fire) begin
                        acc   <= acc_next;
                        carry <= carry | sum_full[WIDTH];
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Results stay visible after the frame until the next start clears them.
    assign out_sum   = acc;
    assign out_carry = carry;
    assign out_count = cnt;

endmodule

// File: tb/tb_cla_accumulator.sv
module tb_cla_accumulator;

    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int CNT_W = 8;
    localparam longint MODV = 64'd1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    int tests = 0;
    int fails = 0;

    cla_accumulator #(
        .WIDTH (WIDTH),
        .GROUP (GROUP),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a frame, 1 collecting operands, 2 result on offer
    int               m_phase = 0;
    longint           m_total = 0;
    logic             m_carry = 1'b0;
    int               m_count = 0;
    int               m_len   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_total <= 0;
            m_carry <= 1'b0;
            m_count <= 0;
            m_len   <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_total <= 0;
                    m_carry <= 1'b0;
                    m_count <= 0;
                    m_len   <= int'(len);
                    m_phase <= (len == 0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    longint s;
                    s = m_total + longint'(in_data);
`ifdef CLA_ACC_SAT_EN
                    m_total <= (s >= MODV) ? MODV - 1 : s;
`else
                    m_total <= s % MODV;
`endif
                    if (s >= MODV) m_carry <= 1'b1;
                    m_count <= m_count + 1;
                    if (m_count + 1 == m_len) m_phase <= 2;
                end
                2: if (out_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("in_ready", in_ready, (m_phase == 1));
        check("out_valid", out_valid, (m_phase == 2));
        check("busy", busy, (m_phase != 0));
        if (m_phase != 1) begin
            check("out_sum", out_sum, m_total[WIDTH-1:0]);
            check("out_carry", out_carry, m_carry);
            check("out_count", out_count, m_count);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = CNT_W'(l);
        @(negedge clk);
        start = 1'b0;
        len   = CNT_W'($urandom_range(0, 255));  // must be ignored mid-frame
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = WIDTH'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("beat_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("done_timeout", 0, 1);
    endtask

    task automatic finish_frame(input int hold, input bit poke_start);
        for (int i = 0; i < hold; i++) begin
            start = poke_start && (i == 1);
            len   = 8'd5;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_sum", out_sum, 0);
        rst = 1'b0;

        // len=3, back-to-back beats
        do_start(3);
        send_beat(16'd120, 0);
        send_beat(16'd100, 0);
        send_beat(16'd12, 0);
        check("t1_latency", out_valid, 1);
        check("t1_sum", out_sum, 232);
        check("t1_carry", out_carry, 0);
        check("t1_count", out_count, 3);
        finish_frame(0, 1'b0);

        // overflow
        do_start(2);
        send_beat(16'hFFFF, 0);
        send_beat(16'hFFFF, 0);
        wait_done();
`ifdef CLA_ACC_SAT_EN
        check("t2_sum", out_sum, 65535);
`else
        check("t2_sum", out_sum, 65534);
`endif
        check("t2_carry", out_carry, 1);
        finish_frame(1, 1'b0);

        // empty frame
        do_start(0);
        check("t3_valid", out_valid, 1);
        check("t3_sum", out_sum, 0);
        check("t3_count", out_count, 0);
        check("t3_in_ready", in_ready, 0);
        finish_frame(2, 1'b0);

        // gaps, held result, start ignored in DONE
        do_start(2);
        send_beat(16'd60, 0);
        send_beat(16'd30, 4);
        wait_done();
        check("t4_sum", out_sum, 90);
        finish_frame(5, 1'b1);
        check("t4_idle_valid", out_valid, 0);
        check("t4_idle_busy", busy, 0);
        check("t4_kept_sum", out_sum, 90);

        // asynchronous reset mid-frame
        do_start(3);
        send_beat(16'd25, 0);
        #2 rst = 1'b1;
        #1;
        check("t5_in_ready", in_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_sum", out_sum, 0);
        @(negedge clk);
        rst = 1'b0;
        do_start(1);
        send_beat(16'd25, 0);
        check("t5_sum_after", out_sum, 25);
        finish_frame(0, 1'b0);

        // streaming with out_ready held high
        out_ready = 1'b1;
        do_start(4);
        send_beat(16'd1000, 0);
        send_beat(16'd3000, 0);
        send_beat(16'd6000, 0);
        send_beat(16'd5, 0);
        check("t6_valid", out_valid, 1);
        check("t6_sum", out_sum, 10005);
        check("t6_count", out_count, 4);
        @(negedge clk);
        check("t6_back_idle", out_valid, 0);
        check("t6_busy", busy, 0);
        out_ready = 1'b0;

        // start coincident with out_ready in DONE
        do_start(1);
        send_beat(16'd7, 0);
        start     = 1'b1;
        len       = 8'd2;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        check("t7_start_ignored", busy, 0);

        // randomized frames
        for (int f = 0; f < 60; f++) begin
            int l;
            l = $urandom_range(0, 7);
            do_start(l);
            for (int b = 0; b < l; b++) begin
                logic [WIDTH-1:0] d;
                d = ($urandom_range(0, 2) == 0) ? WIDTH'(16'hFFFF - $urandom_range(0, 300))
                                                : WIDTH'($urandom);
                send_beat(d, $urandom_range(0, 2));
            end
            wait_done();
            finish_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cla_accumulator.md
Name: cla_accumulator

Overview:
Sequential accumulator that sits directly downstream of the parameterised carry-look-ahead adder. It feeds its own running total back into the adder, so a stream of operands is summed one per cycle. Operands arrive on a valid/ready input stream. A frame of `len` operands is reduced to one WIDTH-bit result plus a sticky carry flag, and the result is presented on a valid/ready output.

Parameters:
- WIDTH, 16, operand and accumulator width; must be a multiple of GROUP.
- GROUP, 4, CLA group size passed to the adder instance.
- CNT_W, 8, width of the frame-length and beat counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- len  in  CNT_W  number of operands in the frame; sampled with start.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid and in_ready are both 1.
- in_data  in  WIDTH  operand.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid and out_ready are both 1.
- out_sum  out  WIDTH  accumulated total.
- out_carry  out  1  sticky: 1 if any add in the frame produced carry-out (sum bit WIDTH).
- out_count  out  CNT_W  beats accepted in the frame.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - acc, carry flag and beat counter clear to 0.
  - in_ready, out_valid and busy are 0; out_sum, out_carry and out_count read 0.
- The adder is a combinational instance of Carry_Look_Ahead_Adder #(WIDTH,GROUP) with a = acc and b = in_data.
  - Its WIDTH+1-bit result is registered into acc (low WIDTH bits) and into the carry flag (bit WIDTH, OR-ed in).
- IDLE:
  - in_ready = 0.
  - start=1 with len>0: clear acc, carry and counter, latch len, go to ACCUM.
  - start=1 with len=0: clear, go straight to DONE; the result is 0, carry 0, count 0.
- ACCUM:
  - in_ready = 1 combinationally; no bubble is required between beats.
  - On each handshake: acc <= (acc+in_data) mod 2^WIDTH; carry <= carry | cout; count++.
  - The handshake where count == len-1 moves to DONE.
  - Cycles with in_valid=0 leave all state unchanged.
- DONE:
  - out_valid = 1; out_sum, out_carry and out_count are stable and equal to acc, carry and count.
  - in_ready = 0.
  - On the out_ready handshake, go to IDLE. out_valid drops the next cycle; out_sum, out_carry and out_count keep their last values until the next start.
- start is ignored outside IDLE.
- len is latched at start; changes to len during a frame have no effect.
- Latency: out_valid rises on the clock edge that accepts the last beat, so it is visible the cycle after the last in handshake. Throughput is one operand per cycle.
- start and out_ready in the same cycle while in DONE: return to IDLE only; start is ignored until the next cycle.

Optional Feature:
CLA_ACC_SAT_EN
- Defined: a carry-out saturates acc to all ones, and acc stays all ones for the rest of the frame. out_carry still reports the sticky carry.
- Undefined: modular wrap-around as described in Behaviour.

Decomposition:
- Package cla_pkg holds:
  - the state typedef {IDLE, ACCUM, DONE};
  - default WIDTH, GROUP and CNT_W constants;
  - a localparam check function asserting WIDTH % GROUP == 0.
- One sub-module: the existing Carry_Look_Ahead_Adder, instantiated once.
- The FSM, counter and accumulator register live in cla_accumulator.

Test Plan (WIDTH=16, GROUP=4):
- start with len=3, beats 120, 100, 12 back-to-back -> out_valid one cycle after the last beat; out_sum=232, out_carry=0, out_count=3.
- len=2, beats 65535, 65535 -> out_sum=65534, out_carry=1. With CLA_ACC_SAT_EN -> out_sum=65535, out_carry=1.
- start with len=0 -> out_valid the next cycle; out_sum=0, out_carry=0, out_count=0; in_ready never asserted.
- len=2, beats 60 and 30 separated by 4 idle in_valid=0 cycles, then out_ready held 0 for 5 cycles -> out_sum=90 and out_valid held stable; in_ready=0; a start pulse during DONE is ignored.
- rst pulsed mid-ACCUM after one beat of 25 -> asynchronous clear: in_ready=0, busy=0, out_sum=0; a new len=1 frame with 25 then yields 25.
- len=4, beats 1000, 3000, 6000, 5 with in_valid and out_ready always 1 -> out_sum=10005, out_count=4; returns to IDLE on the following edge.
